// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, bubble word, fetch FSM states and
// the decode-to-fetch control bundle.
package mips_pkg;

  localparam int          PC_WIDTH_DEFAULT = 32;
  localparam logic [5:0]  OPC_J            = 6'd2;
  localparam logic [5:0]  OPC_JAL          = 6'd3;
  localparam logic [5:0]  OPC_FINISH       = 6'd63;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic jump;
    logic jal;
    logic jump_r;
    logic branch;
    logic branch_not;
    logic regs_equal;
    logic finish;
  } id_ctrl_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, inserts a bubble, or holds.
// Latency: one cycle from load/bubble to output.
// Backpressure: holds contents whenever neither load nor bubble is asserted.
module if_id_reg #(
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                bubble,
  input  logic [31:0]         load_instr,
  input  logic [PC_WIDTH-1:0] load_pc_plus4,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                valid
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      instr    <= NOP_WORD;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= load_instr;
      pc_plus4 <= load_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, imem handshake, DMA yield, ID redirects, finish halt.
// Latency: one instruction per cycle with zero-wait memory; a redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; dma_hold or imem_ready=0 feed bubbles. FETCH_STATS_EN adds counters.
module fetch_stage #(
  parameter int          PC_WIDTH = mips_pkg::PC_WIDTH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  input  logic                dma_hold,
  input  logic                stall,
  input  logic                id_jump,
  input  logic                id_jal,
  input  logic                id_jump_r,
  input  logic                id_branch,
  input  logic                id_branch_not,
  input  logic                id_regs_equal,
  input  logic [PC_WIDTH-1:0] id_branch_target,
  input  logic [PC_WIDTH-1:0] id_jr_target,
  input  logic                id_finish,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc_plus4,
  output logic                if_id_valid,
`ifdef FETCH_STATS_EN
  output logic [31:0]         fetch_count,
  output logic [31:0]         bubble_count,
`endif
  output logic                halted
);

  import mips_pkg::*;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] redirect_target;
  id_ctrl_t            id_ctrl;
  logic                active;
  logic                fetch_vld;
  logic                redirect_vld;
  logic                finish_vld;
  logic                ifid_load;
  logic                ifid_bubble;

  assign id_ctrl = '{jump:       id_jump,
                     jal:        id_jal,
                     jump_r:     id_jump_r,
                     branch:     id_branch,
                     branch_not: id_branch_not,
                     regs_equal: id_regs_equal,
                     finish:     id_finish};

  assign active    = (state_q != HALT);
  assign imem_req  = active && !dma_hold && !reset;
  assign imem_addr = pc_q;
  assign fetch_vld = imem_req && imem_ready;
  assign halted    = (state_q == HALT);
  assign pc_plus4  = pc_q + PC_WIDTH'(4);

  // ID controls are only meaningful while IF/ID holds a real instruction
  assign finish_vld   = if_id_valid && id_ctrl.finish;
  assign redirect_vld = if_id_valid &&
                        (id_ctrl.jump_r || id_ctrl.jump || id_ctrl.jal ||
                         (id_ctrl.branch && id_ctrl.regs_equal) ||
                         (id_ctrl.branch_not && !id_ctrl.regs_equal));

  assign jump_target = {if_id_pc_plus4[PC_WIDTH-1:28], if_id_instr[25:0], 2'b00};

  always_comb begin
    redirect_target = id_branch_target;
    if (id_ctrl.jump_r) begin
      redirect_target = id_jr_target;
    end else if (id_ctrl.jump || id_ctrl.jal) begin
      redirect_target = jump_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC[PC_WIDTH-1:0];
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (active) begin
      state_d = dma_hold ? HOLD : FETCH;
      // A stall freezes everything; ID re-presents redirect/finish next cycle
      if (!stall) begin
        if (finish_vld) begin
          state_d     = HALT;
          ifid_bubble = 1'b1;
        end else if (redirect_vld) begin
          pc_d        = redirect_target;
          ifid_bubble = 1'b1;
        end else if (fetch_vld) begin
          pc_d      = pc_plus4;
          ifid_load = 1'b1;
        end else begin
          ifid_bubble = 1'b1;
        end
      end
    end
  end

  if_id_reg #(
    .PC_WIDTH (PC_WIDTH),
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (ifid_load),
    .bubble        (ifid_bubble),
    .load_instr    (imem_rdata),
    .load_pc_plus4 (pc_plus4),
    .instr         (if_id_instr),
    .pc_plus4      (if_id_pc_plus4),
    .valid         (if_id_valid)
  );

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (ifid_load) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (ifid_bubble) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected IF/ID
// loads, a monitor pops and compares them; inline checks cover PC and handshake.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dma_hold;
  logic        stall;
  logic        id_jump, id_jal, id_jump_r, id_branch, id_branch_not, id_regs_equal;
  logic [31:0] id_branch_target;
  logic [31:0] id_jr_target;
  logic        id_finish;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_ready       (imem_ready),
    .dma_hold         (dma_hold),
    .stall            (stall),
    .id_jump          (id_jump),
    .id_jal           (id_jal),
    .id_jump_r        (id_jump_r),
    .id_branch        (id_branch),
    .id_branch_not    (id_branch_not),
    .id_regs_equal    (id_regs_equal),
    .id_branch_target (id_branch_target),
    .id_jr_target     (id_jr_target),
    .id_finish        (id_finish),
    .if_id_instr      (if_id_instr),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid),
    .halted           (halted)
  );

  // Address-tagged memory; word 0xC is "j 0x40"
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0800_0040;
    return {8'hAC, a[23:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.instr = mem_word(addr);
    e.pc4   = addr + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a fresh IF/ID load is any valid word after a non-stalled edge
  initial begin
    logic st;
    exp_t e;
    forever begin
      @(posedge clk);
      st = stall | reset;
      @(negedge clk);
      if (if_id_valid && !st) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got instr %h pc4 %h with nothing expected",
                   if_id_instr, if_id_pc_plus4);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", if_id_instr, e.instr);
          check("sb_pc4", if_id_pc_plus4, e.pc4);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; imem_ready = 1'b1; dma_hold = 1'b0; stall = 1'b0;
    id_jump = 1'b0; id_jal = 1'b0; id_jump_r = 1'b0; id_branch = 1'b0;
    id_branch_not = 1'b0; id_regs_equal = 1'b0; id_finish = 1'b0;
    id_branch_target = '0; id_jr_target = '0;
    step(); step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc4", if_id_pc_plus4, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);

    // Sequential fetch with zero-wait memory
    reset = 1'b0; #1;
    check("seq_req", 32'(imem_req), 32'd1);
    check("seq_addr0", imem_addr, 32'h0);
    push(32'h0); step();
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_valid", 32'(if_id_valid), 32'd1);
    push(32'h4); step();
    check("seq_addr8", imem_addr, 32'h8);
    push(32'h8); step();
    push(32'hC); step();
    check("j_pc4", if_id_pc_plus4, 32'h10);

    // j 0x40 from pc_plus4 0x10 -> 0x100, one bubble
    id_jump = 1'b1; step(); id_jump = 1'b0;
    check("j_addr", imem_addr, 32'h100);
    check("j_bubble", 32'(if_id_valid), 32'd0);
    check("j_nop", if_id_instr, 32'h0);
    push(32'h100); step();

    // bne with equal operands falls through
    id_branch_not = 1'b1; id_regs_equal = 1'b1;
    push(32'h104); step();
    id_branch_not = 1'b0;
    check("bne_addr", imem_addr, 32'h108);

    // beq taken to 0x200
    id_branch = 1'b1; id_branch_target = 32'h200; step();
    id_branch = 1'b0; id_regs_equal = 1'b0;
    check("beq_addr", imem_addr, 32'h200);
    check("beq_bubble", 32'(if_id_valid), 32'd0);
    push(32'h200); step();

    // jr under stall is deferred until the stall drops
    stall = 1'b1; id_jump_r = 1'b1; id_jr_target = 32'h300;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_addr", imem_addr, 32'h204);
      check("stall_pc4", if_id_pc_plus4, 32'h204);
      check("stall_valid", 32'(if_id_valid), 32'd1);
    end
    stall = 1'b0; step();
    check("jr_addr", imem_addr, 32'h300);
    check("jr_bubble", 32'(if_id_valid), 32'd0);
    id_jump_r = 1'b0;
    push(32'h300); step();
    id_jump_r = 1'b1; id_jr_target = 32'h20; step(); id_jump_r = 1'b0;
    check("jr20_addr", imem_addr, 32'h20);

    // DMA owns the bus for 3 cycles at pc 0x20
    dma_hold = 1'b1; #1;
    check("dma_req_drop", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("dma_req", 32'(imem_req), 32'd0);
      check("dma_addr", imem_addr, 32'h20);
      check("dma_bubble", 32'(if_id_valid), 32'd0);
    end
    dma_hold = 1'b0; #1;
    check("dma_resume_req", 32'(imem_req), 32'd1);
    check("dma_resume_addr", imem_addr, 32'h20);
    push(32'h20); step();

    // Wait states keep the request and address stable
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, 32'h24);
      check("wait_bubble", 32'(if_id_valid), 32'd0);
    end
    imem_ready = 1'b1;
    push(32'h24); step();

    // Finish halts fetch until reset
    id_finish = 1'b1; step(); id_finish = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(if_id_valid), 32'd0);
      step();
    end
    reset = 1'b1; step();
    check("rst2_halted", 32'(halted), 32'd0);
    reset = 1'b0; #1;
    check("rst2_req", 32'(imem_req), 32'd1);
    check("rst2_addr", imem_addr, 32'h0);
    push(32'h0); step();
    step();
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core that owns the PC and the IF/ID pipeline register, and feeds the decode/control stage.
- Talks to instruction memory over a req/ready handshake.
- Yields the bus while the DMA controller holds it.
- Applies jump, jal, jr and branch redirects resolved in ID, inserting bubbles on redirect.
- Stops fetching permanently once decode reports a finish (opcode 63) instruction.

Parameters:
PC_WIDTH, 32, width of PC, addresses, instruction word
RESET_PC, 32'h0000_0000, PC value after reset
NOP_WORD, 32'h0000_0000, bubble instruction (sll $0,$0,0)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request
imem_addr  output  PC_WIDTH  fetch address (= pc)
imem_rdata  input  32  instruction, valid when imem_ready=1
imem_ready  input  1  memory completes request this cycle
dma_hold  input  1  DMA owns bus; no fetch allowed
stall  input  1  hazard unit: hold PC and IF/ID
id_jump  input  1  decode: j
id_jal  input  1  decode: jal
id_jump_r  input  1  decode: jr
id_branch  input  1  decode: beq
id_branch_not  input  1  decode: bne
id_regs_equal  input  1  ID comparator, rs==rt
id_branch_target  input  PC_WIDTH  ID pc_plus4 + (sext(imm)<<2)
id_jr_target  input  PC_WIDTH  rs value for jr
id_finish  input  1  decode: finish instruction
if_id_instr  output  32  IF/ID instruction
if_id_pc_plus4  output  PC_WIDTH  IF/ID PC+4
if_id_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch stopped after finish

Behaviour:
- Reset values: pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0, halted=0, imem_req=0 during reset cycle, state=FETCH.
- FSM: FETCH (imem_req=~dma_hold), HOLD (dma_hold=1, imem_req=0), HALT (imem_req=0, halted=1). FETCH<->HOLD follow dma_hold each cycle. Any state->HALT on accepted finish. HALT exits only by reset.
- Redirect: redirect = id_jump_r | id_jump | id_jal | (id_branch & id_regs_equal) | (id_branch_not & ~id_regs_equal).
- Target priority: jr -> id_jr_target; j/jal -> {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}; branch -> id_branch_target.
- ID signals apply only when if_id_valid=1.
- Per-edge priority:
  1. reset.
  2. HALT: nothing changes.
  3. stall=1: pc and IF/ID held. Redirect and finish are ignored this cycle; ID re-presents them next cycle.
  4. id_finish: go HALT, IF/ID <- bubble.
  5. redirect: pc <- target, IF/ID <- bubble. A concurrent imem response is discarded.
  6. fetch completes (FETCH & imem_ready): IF/ID <- {imem_rdata, pc+4, valid=1}, pc <- pc+4.
  7. otherwise (HOLD or not ready): IF/ID <- bubble, pc held.
- Bubble = {NOP_WORD, 0, valid=0}.
- Latency: zero-wait memory gives one instruction per cycle. Redirect costs exactly one bubble.
- imem_addr is stable while imem_req=1 and not ready. It may change only on a redirect; memory treats each cycle independently.
- pc+4 wraps modulo 2^PC_WIDTH.
- dma_hold asserted mid-wait drops imem_req the same cycle. The request is reissued from the same pc.

Optional Feature:
FETCH_STATS_EN:
- Defined: adds outputs fetch_count[31:0] (completed fetches) and bubble_count[31:0] (cycles IF/ID loaded a bubble while not HALT). Both reset to 0 and wrap.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - OPC_J=2, OPC_JAL=3, OPC_FINISH=63
  - NOP_WORD
  - fetch state typedef {FETCH, HOLD, HALT}
  - PC_WIDTH default
- Natural sub-module: if_id_reg, the pipeline register with load/hold/bubble controls. Next-PC mux and FSM stay in fetch_stage.

Test Plan:
- Reset, imem_ready=1, memory returns addr-tagged words -> imem_addr 0,4,8; if_id_pc_plus4 4,8,12 on consecutive cycles; if_id_valid=1 from second cycle.
- j with if_id_instr[25:0]=0x40, if_id_pc_plus4=0x10 -> next imem_addr=0x100, one bubble (valid=0) in IF/ID.
- bne with id_regs_equal=1 -> no redirect, sequential fetch. beq with equal=1, target 0x200 -> pc=0x200.
- stall=1 together with jr to 0x300 for 2 cycles -> pc and IF/ID unchanged. Redirect to 0x300 applies on first non-stalled cycle.
- dma_hold=1 for 3 cycles at pc=0x20 -> imem_req=0, 3 bubbles, then fetch resumes at 0x20.
- id_finish with valid=1 -> halted=1 next cycle, imem_req=0 forever. Reset then restarts at RESET_PC.
